tdm_demux_1x2: RTL and testbench

TDM_DEMUX_1X2 -- requirements
Module: tdm_demux_1x2

---
 rtl/tdm_demux_1x2.sv | 78 +++++++
 tb/tb_tdm_demux_1x2.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x2.sv
// Two-channel TDM demultiplexer: splits an interleaved serial stream (even bits ->
// channel 0, odd bits -> channel 1, MSB first) into parallel words, framed by fsync.
module tdm_demux_1x2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             fsync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             y_vld,
  output logic             locked,
  output logic             sync_err
);

  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;

  assign locked = (state == RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      cnt      <= '0;
      sh0      <= '0;
      sh1      <= '0;
      y0       <= '0;
      y1       <= '0;
      y_vld    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      y_vld    <= 1'b0;
      sync_err <= 1'b0;
      if (din_vld) begin
        case (state)
          HUNT: begin
            if (fsync) begin
              sh0   <= {sh0[WIDTH-2:0], din};
              cnt   <= CW'(1);
              state <= RECV;
            end
          end
          RECV: begin
            if (fsync) begin
              // fsync anywhere but frame start aborts the partial frame and restarts on this bit
              sync_err <= (cnt != '0);
              sh0      <= {sh0[WIDTH-2:0], din};
              cnt      <= CW'(1);
            end else if (cnt == '0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end else if (cnt == LAST) begin
              y0    <= sh0;
              y1    <= {sh1[WIDTH-2:0], din};
              y_vld <= 1'b1;
              cnt   <= '0;
            end else begin
              if (cnt[0]) sh1 <= {sh1[WIDTH-2:0], din};
              else        sh0 <= {sh0[WIDTH-2:0], din};
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x2.sv
// Directed bench for tdm_demux_1x2 (WIDTH=8): completed frames go through a
// scoreboard queue popped on y_vld; framing errors and timing checked inline.
module tb_tdm_demux_1x2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         din = 1'b0;
  logic         din_vld = 1'b0;
  logic         fsync = 1'b0;
  logic [W-1:0] y0, y1;
  logic         y_vld, locked, sync_err;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int err_seen = 0;
  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   last_y0 = '0;
  logic [W-1:0]   last_y1 = '0;

  tdm_demux_1x2 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .fsync(fsync),
    .y0(y0), .y1(y1), .y_vld(y_vld), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every y_vld must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (y_vld === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_y_vld", 32'(y_vld), 32'd0);
        end else begin
          logic [2*W-1:0] e;
          e = sb_q.pop_front();
          chk("sb_y0", 32'(y0), 32'(e[2*W-1:W]));
          chk("sb_y1", 32'(y1), 32'(e[W-1:0]));
          $display("frame out y0=%02h y1=%02h", y0, y1);
        end
      end
      if (sync_err === 1'b1) err_seen++;
      if (y_vld === 1'b1 && sync_err === 1'b1) chk("vld_and_err", 32'd1, 32'd0);
    end
  end

  task automatic cycle(input logic d, input logic f, input logic v);
    @(negedge clk);
    din = d; fsync = f; din_vld = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic bit_of(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    return (k % 2 == 1) ? b[W-1-k/2] : a[W-1-k/2];
  endfunction

  // Sends bits k0..2W-1 of frame a/b; gap_mask inserts idle cycles (random din/fsync) before bit k.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] gap_mask, input logic err0);
    for (int k = 0; k < 2*W; k++) begin
      if (gap_mask[k]) cycle(1'($urandom), 1'($urandom), 1'b0);
      if (k == 2*W-1) sb_q.push_back({a, b});
      cycle(bit_of(a, b, k), k == 0, 1'b1);
      if (k == 0) begin
        chk("locked_k0", 32'(locked), 32'd1);
        chk("sync_err_k0", 32'(sync_err), 32'(err0));
        if (err0) err_exp++;
      end else if (k < 2*W-1) begin
        chk("no_early_vld", 32'(y_vld), 32'd0);
      end
    end
    chk("y_vld_last", 32'(y_vld), 32'd1);
    chk("y0_last", 32'(y0), 32'(a));
    chk("y1_last", 32'(y1), 32'(b));
    last_y0 = a; last_y1 = b;
    $display("frame in  ch0=%02h ch1=%02h", a, b);
  endtask

  initial begin
    logic [2*W-1:0] gm;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y0", 32'(y0), 32'd0);
    chk("rst_y1", 32'(y1), 32'd0);
    chk("rst_vld", 32'(y_vld), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(sync_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Hunt: unframed bits ignored silently
    for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'b0, 1'b1);
    chk("hunt_locked", 32'(locked), 32'd0);
    chk("hunt_err", 32'(err_seen), 32'(err_exp));

    // Single frame, then single-pulse check
    send_frame(8'hA5, 8'h3C, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("vld_single", 32'(y_vld), 32'd0);
    chk("hold_y0", 32'(y0), 32'hA5);

    // Back-to-back frames, continuous din_vld
    send_frame(8'h01, 8'h80, '0, 1'b0);
    send_frame(8'hFF, 8'h00, '0, 1'b0);
    send_frame(8'h5A, 8'hC3, '0, 1'b0);

    // Three idle cycles at random points inside a frame
    gm = '0;
    while ($countones(gm) < 3) gm[$urandom_range(2*W-1, 1)] = 1'b1;
    send_frame(8'hA5, 8'h3C, gm, 1'b0);

    // fsync reasserted at k=5 aborts the frame and restarts it
    for (int k = 0; k < 5; k++) cycle(bit_of(8'hEE, 8'h77, k), k == 0, 1'b1);
    send_frame(8'h12, 8'h34, '0, 1'b1);

    // Missing fsync at frame start drops lock
    cycle(1'b1, 1'b0, 1'b1);
    chk("nofs_err", 32'(sync_err), 32'd1);
    chk("nofs_locked", 32'(locked), 32'd0);
    chk("nofs_y0", 32'(y0), 32'(last_y0));
    chk("nofs_y1", 32'(y1), 32'(last_y1));
    err_exp++;
    for (int i = 0; i < 4; i++) cycle(1'($urandom), 1'b0, 1'b1);
    chk("nofs_quiet", 32'(err_seen), 32'(err_exp));
    chk("nofs_still_unlocked", 32'(locked), 32'd0);

    // Async reset in the middle of bit k=9
    for (int k = 0; k < 9; k++) cycle(bit_of(8'hAA, 8'h55, k), k == 0, 1'b1);
    @(negedge clk);
    din = bit_of(8'hAA, 8'h55, 9); fsync = 1'b0; din_vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y0", 32'(y0), 32'd0);
    chk("arst_y1", 32'(y1), 32'd0);
    chk("arst_vld", 32'(y_vld), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    din_vld = 1'b0;
    rst_n = 1'b1;
    for (int k = 9; k < 2*W; k++) cycle(bit_of(8'hAA, 8'h55, k), 1'b0, 1'b1);
    chk("post_rst_locked", 32'(locked), 32'd0);
    send_frame(8'hC3, 8'h96, '0, 1'b0);

    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("err_count", 32'(err_seen), 32'(err_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
